// File: rtl/mips_lsu.sv
// MIPS load/store unit: sub-word loads with extension, read-modify-write byte/half stores.
// Optional MIPS_LSU_MISALIGN_TRAP_EN: misaligned requests trap instead of being force-aligned.
module mips_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        exc_misaligned,
  output logic [31:0] exc_addr
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR} state_t;

  state_t      state;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        sgn;
  logic [4:0]  rd;
  logic [1:0]  lane_fix;

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] sz, input logic sx);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (sz)
      2'b00:   return sx ? {{24{sh[7]}}, sh[7:0]} : {24'h000000, sh[7:0]};
      2'b01:   return sx ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] lane, input logic [1:0] sz);
    logic [31:0] r;
    r = old;
    if (sz == 2'b00) begin
      case (lane)
        2'b00:   r[7:0]   = wd[7:0];
        2'b01:   r[15:8]  = wd[7:0];
        2'b10:   r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = wd[15:0];
    end else begin
      r[15:0] = wd[15:0];
    end
    return r;
  endfunction

  // Misaligned offsets are dropped to the natural boundary; aligned ones pass unchanged.
  always_comb begin
    lane_fix = 2'b00;
    case (req_size)
      2'b00:   lane_fix = req_addr[1:0];
      2'b01:   lane_fix = {req_addr[1], 1'b0};
      default: lane_fix = 2'b00;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign mem_read  = (state == LOAD) || (state == RMW_RD);
  assign mem_write = (state == STORE) || (state == RMW_WR);
  assign mem_addr  = (state == IDLE) ? 32'h0000_0000 : {addr[31:2], 2'b00};
  assign mem_wdata = mem_write ? wdata : 32'h0000_0000;

`ifdef MIPS_LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign exc_misaligned = 1'b0;
  assign exc_addr       = 32'h0000_0000;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= 32'h0000_0000;
      wdata    <= 32'h0000_0000;
      size     <= 2'b00;
      sgn      <= 1'b0;
      rd       <= 5'd0;
      wb_valid <= 1'b0;
      wb_data  <= 32'h0000_0000;
      wb_rd    <= 5'd0;
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
      exc_misaligned <= 1'b0;
      exc_addr       <= 32'h0000_0000;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
      exc_misaligned <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid) begin
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
            if (misaligned) begin
              exc_misaligned <= 1'b1;
              exc_addr       <= req_addr;
            end else
`endif
            begin
              addr  <= {req_addr[31:2], lane_fix};
              wdata <= req_wdata;
              size  <= req_size;
              sgn   <= req_signed;
              rd    <= req_rd;
              if (!req_write)       state <= LOAD;
              else if (req_size[1]) state <= STORE;
              else                  state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          wb_valid <= 1'b1;
          wb_data  <= load_extract(mem_rdata, addr[1:0], size, sgn);
          wb_rd    <= rd;
          state    <= IDLE;
        end
        // The merged word replaces wdata so RMW_WR can drive it straight out.
        RMW_RD: begin
          wdata <= store_merge(mem_rdata, wdata, addr[1:0], size);
          state <= RMW_WR;
        end
        STORE:   state <= IDLE;
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_lsu.sv
// Directed bench for mips_lsu with a little-endian word memory model.
module tb_mips_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        exc_misaligned;
  logic [31:0] exc_addr;

  logic [31:0] mem [0:63];
  int tests = 0;
  int fails = 0;
  int wcount = 0;
  int both_hi = 0;

  mips_lsu dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .exc_misaligned(exc_misaligned),
    .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      wcount = wcount + 1;
    end
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) both_hi = both_hi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sx;
    req_addr = a; req_wdata = wd; req_rd = r;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
    mem[4]  = 32'h8899AABB;
    mem[5]  = 32'h0BADF00D;
    mem[12] = 32'h11223344;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    repeat (3) step();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_memrw", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_exc", {31'd0, exc_misaligned}, 32'd0);
    reset = 1'b0;
    step();

    // LB signed 0x11
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 5'd5);
    chk("lb_mem_read", {31'd0, mem_read}, 32'd1);
    chk("lb_mem_addr", mem_addr, 32'h10);
    chk("lb_ready_low", {31'd0, req_ready}, 32'd0);
    chk("lb_wb_early", {31'd0, wb_valid}, 32'd0);
    step();
    chk("lb_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lb_wb_data", wb_data, 32'hFFFFFFAA);
    chk("lb_wb_rd", {27'd0, wb_rd}, 32'd5);
    chk("lb_read_done", {31'd0, mem_read}, 32'd0);
    step();
    chk("lb_wb_pulse", {31'd0, wb_valid}, 32'd0);
    chk("lb_wb_hold", wb_data, 32'hFFFFFFAA);

    // LBU 0x11
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 5'd6);
    step();
    chk("lbu_wb_data", wb_data, 32'h000000AA);
    chk("lbu_wb_rd", {27'd0, wb_rd}, 32'd6);

    // LH signed 0x12
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 5'd9);
    step();
    chk("lh_wb_data", wb_data, 32'hFFFF8899);

    // SH 0x12
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 5'd0);
    chk("sh_rmw_rd", {30'd0, mem_read, mem_write}, 32'd2);
    chk("sh_ready_low1", {31'd0, req_ready}, 32'd0);
    step();
    chk("sh_rmw_wr", {30'd0, mem_read, mem_write}, 32'd1);
    chk("sh_wdata", mem_wdata, 32'h1234AABB);
    chk("sh_ready_low2", {31'd0, req_ready}, 32'd0);
    step();
    chk("sh_ready_back", {31'd0, req_ready}, 32'd1);
    chk("sh_mem_word", mem[4], 32'h1234AABB);
    chk("sh_no_wb", {31'd0, wb_valid}, 32'd0);

    // SB 0x13
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000CC, 5'd0);
    step();
    step();
    chk("sb_mem_word", mem[4], 32'hCC34AABB);

    // SW 0x20
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 5'd0);
    chk("sw_write", {30'd0, mem_read, mem_write}, 32'd1);
    chk("sw_addr", mem_addr, 32'h20);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    chk("sw_one_cycle", {30'd0, mem_read, mem_write}, 32'd0);
    chk("sw_mem_word", mem[8], 32'hDEADBEEF);
    chk("sw_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("sw_ready", {31'd0, req_ready}, 32'd1);

    // LW misaligned 0x22
    issue(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 5'd3);
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
    chk("mis_exc", {31'd0, exc_misaligned}, 32'd1);
    chk("mis_exc_addr", exc_addr, 32'h22);
    chk("mis_no_access", {30'd0, mem_read, mem_write}, 32'd0);
    chk("mis_ready", {31'd0, req_ready}, 32'd1);
    step();
    chk("mis_exc_pulse", {31'd0, exc_misaligned}, 32'd0);
    chk("mis_no_wb", {31'd0, wb_valid}, 32'd0);
`else
    chk("mis_read", {31'd0, mem_read}, 32'd1);
    chk("mis_addr", mem_addr, 32'h20);
    step();
    chk("mis_wb_data", wb_data, 32'hDEADBEEF);
    chk("mis_exc_tied", {31'd0, exc_misaligned}, 32'd0);
`endif

    // SB 0x30 abandoned by reset during RMW_RD
    wcount = 0;
    issue(1'b1, 2'b00, 1'b0, 32'h30, 32'h00000055, 5'd0);
    chk("abort_in_rmw_rd", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    step();
    chk("abort_memrw", {30'd0, mem_read, mem_write}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_wb", {31'd0, wb_valid}, 32'd0);
    chk("abort_wb_data", wb_data, 32'h0);
    chk("abort_wb_rd", {27'd0, wb_rd}, 32'd0);
    // request held during reset must not be taken
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    step();
    req_valid = 1'b0;
    reset = 1'b0;
    chk("rst_prio_no_read", {31'd0, mem_read}, 32'd0);
    step();
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_no_write", wcount, 32'd0);
    chk("abort_mem_word", mem[12], 32'h11223344);

    // back-to-back LW with req_valid held
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_rd = 5'd7;
    step();
    chk("b2b_load1", {31'd0, mem_read}, 32'd1);
    req_addr = 32'h14; req_rd = 5'd8;
    step();
    chk("b2b_wb1_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b_wb1_data", wb_data, 32'hCC34AABB);
    chk("b2b_wb1_rd", {27'd0, wb_rd}, 32'd7);
    chk("b2b_idle_gap", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    chk("b2b_load2_addr", mem_addr, 32'h14);
    chk("b2b_wb_gap", {31'd0, wb_valid}, 32'd0);
    step();
    chk("b2b_wb2_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b_wb2_data", wb_data, 32'h0BADF00D);
    chk("b2b_wb2_rd", {27'd0, wb_rd}, 32'd8);
    step();
    chk("rw_exclusive", both_hi, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
